// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg_pkg
//  Description : Shared constants for the ID/EX pipeline register. Holds the
//                EX operand-mux select encoding and the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package id_ex_stage_reg_pkg;

    // EX operand / forwarding mux select codes
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;
    localparam logic [1:0] FWD_IMM     = 2'b11;

    // Default datapath and register-index widths
    localparam int DEFAULT_NB_DATA = 32;
    localparam int DEFAULT_NB_REG  = 5;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg_fwd_select
//  Description : Combinational forwarding match for one source index. The
//                "near" candidate is the instruction now in ID/EX (it will be
//                in EX/MEM next cycle); the "far" candidate is the one now in
//                EX/MEM (MEM/WB next cycle). Near wins; index 0 never matches.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage_reg_fwd_select
    import id_ex_stage_reg_pkg::*;
#(
    parameter int NB_REG = DEFAULT_NB_REG
) (
    input  logic [NB_REG-1:0] i_src_idx,
    input  logic              i_near_wr,
    input  logic [NB_REG-1:0] i_near_rd,
    input  logic              i_far_wr,
    input  logic [NB_REG-1:0] i_far_rd,
    output logic [1:0]        o_sel
);

    logic w_near_hit;
    logic w_far_hit;

    assign w_near_hit = i_near_wr && (i_near_rd != '0) && (i_near_rd == i_src_idx);
    assign w_far_hit  = i_far_wr  && (i_far_rd  != '0) && (i_far_rd  == i_src_idx);

    // Priority encode: most recent producer first
    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_near_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_far_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : ID/EX pipeline register. Captures operands, immediate and
//                control from ID, precomputes the three EX operand-mux
//                selects one cycle early and flags load-use hazards against
//                the instruction it currently holds.
//  Config      : ID_EX_FWD_PRECOMPUTE_EN - when defined, forwarding selects
//                are computed from index compares; when undefined only the
//                immediate select on ALU B is produced.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int NB_DATA = DEFAULT_NB_DATA,
    parameter int NB_REG  = DEFAULT_NB_REG,
    parameter int NB_CTRL = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic               i_alu_src,
    input  logic               i_uses_rt,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_REG-1:0]  i_exmem_rd,
    input  logic               i_exmem_reg_write,
    output logic               o_valid,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [1:0]         o_fwd_a_sel,
    output logic [1:0]         o_fwd_b_sel,
    output logic [1:0]         o_fwd_st_sel,
    output logic               o_load_use_hazard
);

    logic               valid_q,     valid_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [NB_REG-1:0]  rs_q,        rs_d;
    logic [NB_REG-1:0]  rt_q,        rt_d;
    logic [NB_REG-1:0]  rd_q,        rd_d;
    logic [NB_DATA-1:0] rs_data_q,   rs_data_d;
    logic [NB_DATA-1:0] rt_data_q,   rt_data_d;
    logic [NB_DATA-1:0] imm_q,       imm_d;
    logic [NB_CTRL-1:0] ctrl_q,      ctrl_d;
    logic [1:0]         fwd_a_q,     fwd_a_d;
    logic [1:0]         fwd_b_q,     fwd_b_d;
    logic [1:0]         fwd_st_q,    fwd_st_d;

    // Select codes for the instruction currently presented by ID
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_st;

`ifdef ID_EX_FWD_PRECOMPUTE_EN
    logic       w_near_wr;
    logic [1:0] w_match_a;
    logic [1:0] w_match_b;
    logic [1:0] w_match_st;

    // The held instruction only forwards if it is real and writes a register
    assign w_near_wr = valid_q & reg_write_q;

    id_ex_stage_reg_fwd_select #(.NB_REG(NB_REG)) u_fwd_a (
        .i_src_idx (i_rs),
        .i_near_wr (w_near_wr),
        .i_near_rd (rd_q),
        .i_far_wr  (i_exmem_reg_write),
        .i_far_rd  (i_exmem_rd),
        .o_sel     (w_match_a)
    );

    id_ex_stage_reg_fwd_select #(.NB_REG(NB_REG)) u_fwd_b (
        .i_src_idx (i_rt),
        .i_near_wr (w_near_wr),
        .i_near_rd (rd_q),
        .i_far_wr  (i_exmem_reg_write),
        .i_far_rd  (i_exmem_rd),
        .o_sel     (w_match_b)
    );

    id_ex_stage_reg_fwd_select #(.NB_REG(NB_REG)) u_fwd_st (
        .i_src_idx (i_rt),
        .i_near_wr (w_near_wr),
        .i_near_rd (rd_q),
        .i_far_wr  (i_exmem_reg_write),
        .i_far_rd  (i_exmem_rd),
        .o_sel     (w_match_st)
    );

    assign w_fwd_a  = w_match_a;
    assign w_fwd_st = w_match_st;
    assign w_fwd_b  = i_alu_src ? FWD_IMM : w_match_b;
`else
    // No compare logic: register file everywhere, immediate on ALU B
    logic w_unused_exmem;

    assign w_unused_exmem = &{1'b0, i_exmem_rd, i_exmem_reg_write};
    assign w_fwd_a        = FWD_REGFILE;
    assign w_fwd_st       = FWD_REGFILE;
    assign w_fwd_b        = i_alu_src ? FWD_IMM : FWD_REGFILE;
`endif

    // Next state: hold when disabled, bubble on flush, otherwise load
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        fwd_st_d    = fwd_st_q;
        if (i_enable) begin
            // Payload loads even for a bubble; it is never consumed then
            rs_d      = i_rs;
            rt_d      = i_rt;
            rd_d      = i_rd;
            rs_data_d = i_rs_data;
            rt_data_d = i_rt_data;
            imm_d     = i_imm;
            ctrl_d    = i_ctrl;
            if (i_flush) begin
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                fwd_a_d     = FWD_REGFILE;
                fwd_b_d     = FWD_REGFILE;
                fwd_st_d    = FWD_REGFILE;
            end else begin
                valid_d     = i_valid;
                reg_write_d = i_reg_write & i_valid;
                mem_read_d  = i_mem_read  & i_valid;
                mem_write_d = i_mem_write & i_valid;
                fwd_a_d     = w_fwd_a;
                fwd_b_d     = w_fwd_b;
                fwd_st_d    = w_fwd_st;
            end
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            fwd_a_q     <= FWD_REGFILE;
            fwd_b_q     <= FWD_REGFILE;
            fwd_st_q    <= FWD_REGFILE;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            fwd_st_q    <= fwd_st_d;
        end
    end

    // A held load whose destination ID needs next cycle cannot be forwarded
    assign o_load_use_hazard = valid_q & mem_read_q & (rd_q != '0) &
                               ((rd_q == i_rs) | (i_uses_rt & (rd_q == i_rt))) &
                               i_valid;

    assign o_valid      = valid_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_rs         = rs_q;
    assign o_rt         = rt_q;
    assign o_rd         = rd_q;
    assign o_rs_data    = rs_data_q;
    assign o_rt_data    = rt_data_q;
    assign o_imm        = imm_q;
    assign o_ctrl       = ctrl_q;
    assign o_fwd_a_sel  = fwd_a_q;
    assign o_fwd_b_sel  = fwd_b_q;
    assign o_fwd_st_sel = fwd_st_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage_reg
//  Description : Self-checking bench for id_ex_stage_reg. Vector table plus
//                reference model feeding a scoreboard queue; hand sequences
//                for asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage_reg;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable, i_flush, i_valid;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic        i_alu_src, i_uses_rt, i_reg_write, i_mem_read, i_mem_write;
    logic [7:0]  i_ctrl;
    logic [4:0]  i_exmem_rd;
    logic        i_exmem_reg_write;
    logic        o_valid, o_reg_write, o_mem_read, o_mem_write;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [31:0] o_rs_data, o_rt_data, o_imm;
    logic [7:0]  o_ctrl;
    logic [1:0]  o_fwd_a_sel, o_fwd_b_sel, o_fwd_st_sel;
    logic        o_load_use_hazard;

    id_ex_stage_reg dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
        .i_valid(i_valid), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_alu_src(i_alu_src), .i_uses_rt(i_uses_rt), .i_reg_write(i_reg_write),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_ctrl(i_ctrl),
        .i_exmem_rd(i_exmem_rd), .i_exmem_reg_write(i_exmem_reg_write),
        .o_valid(o_valid), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
        .o_ctrl(o_ctrl), .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
        .o_fwd_st_sel(o_fwd_st_sel), .o_load_use_hazard(o_load_use_hazard)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en, fl, vl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic        alu, urt, rw, mr, mw;
        logic [7:0]  ctrl;
        logic [4:0]  exrd;
        logic        exrw;
        logic        haz;   // expected same-cycle load-use flag
    } vec_t;

    typedef struct {
        logic        valid, rw, mr, mw;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [7:0]  ctrl;
        logic [1:0]  a, b, st;
        logic        dc;    // payload is don't-care (bubble)
    } exp_t;

    exp_t   m;
    exp_t   sb[$];
    vec_t   tbl[19];
    int     n_err = 0;
    int     n_chk = 0;
    int     step_no = 0;

    function automatic vec_t mkv(input logic en, fl, vl, input logic [4:0] rs, rt, rd,
                                 input logic alu, urt, rw, mr, mw,
                                 input logic [4:0] exrd, input logic exrw, input logic haz);
        vec_t v;
        v.en = en; v.fl = fl; v.vl = vl; v.rs = rs; v.rt = rt; v.rd = rd;
        v.alu = alu; v.urt = urt; v.rw = rw; v.mr = mr; v.mw = mw;
        v.exrd = exrd; v.exrw = exrw; v.haz = haz;
        v.rsd = 32'h0; v.rtd = 32'h0; v.imm = 32'h0; v.ctrl = 8'h0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %0h expected %0h", step_no, nm, act, exp);
        end
    endtask

    // Reference forwarding match against model state (near) and EX/MEM (far)
    function automatic logic [1:0] fmatch(input logic [4:0] s, input vec_t v);
        if (m.valid && m.rw && m.rd != 5'd0 && m.rd == s) return 2'b01;
        if (v.exrw && v.exrd != 5'd0 && v.exrd == s)       return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic mhaz(input vec_t v);
        return m.valid && m.mr && m.rd != 5'd0 &&
               (m.rd == v.rs || (v.urt && m.rd == v.rt)) && v.vl;
    endfunction

    task automatic model_next(input vec_t v);
        exp_t n;
        n = m;
        if (v.en) begin
            n.rs = v.rs; n.rt = v.rt; n.rd = v.rd;
            n.rsd = v.rsd; n.rtd = v.rtd; n.imm = v.imm; n.ctrl = v.ctrl;
            if (v.fl) begin
                n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
                n.a = 0; n.b = 0; n.st = 0; n.dc = 1;
            end else begin
                n.valid = v.vl; n.rw = v.rw & v.vl; n.mr = v.mr & v.vl; n.mw = v.mw & v.vl;
                n.dc = 0;
`ifdef ID_EX_FWD_PRECOMPUTE_EN
                n.a  = fmatch(v.rs, v);
                n.st = fmatch(v.rt, v);
                n.b  = v.alu ? 2'b11 : fmatch(v.rt, v);
`else
                n.a  = 2'b00;
                n.st = 2'b00;
                n.b  = v.alu ? 2'b11 : 2'b00;
`endif
            end
        end
        m = n;
        sb.push_back(n);
    endtask

    task automatic drive(input vec_t v);
        i_enable = v.en; i_flush = v.fl; i_valid = v.vl;
        i_rs = v.rs; i_rt = v.rt; i_rd = v.rd;
        i_rs_data = v.rsd; i_rt_data = v.rtd; i_imm = v.imm;
        i_alu_src = v.alu; i_uses_rt = v.urt;
        i_reg_write = v.rw; i_mem_read = v.mr; i_mem_write = v.mw;
        i_ctrl = v.ctrl; i_exmem_rd = v.exrd; i_exmem_reg_write = v.exrw;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL step %0d scoreboard: got empty queue expected entry", step_no);
            return;
        end
        e = sb.pop_front();
        chk("valid",     {31'b0, o_valid},     {31'b0, e.valid});
        chk("reg_write", {31'b0, o_reg_write}, {31'b0, e.rw});
        chk("mem_read",  {31'b0, o_mem_read},  {31'b0, e.mr});
        chk("mem_write", {31'b0, o_mem_write}, {31'b0, e.mw});
        chk("fwd_a",     {30'b0, o_fwd_a_sel}, {30'b0, e.a});
        chk("fwd_b",     {30'b0, o_fwd_b_sel}, {30'b0, e.b});
        chk("fwd_st",    {30'b0, o_fwd_st_sel},{30'b0, e.st});
        if (!e.dc) begin
            chk("rs",      {27'b0, o_rs}, {27'b0, e.rs});
            chk("rt",      {27'b0, o_rt}, {27'b0, e.rt});
            chk("rd",      {27'b0, o_rd}, {27'b0, e.rd});
            chk("rs_data", o_rs_data, e.rsd);
            chk("rt_data", o_rt_data, e.rtd);
            chk("imm",     o_imm,     e.imm);
            chk("ctrl",    {24'b0, o_ctrl}, {24'b0, e.ctrl});
        end
    endtask

    // One cycle: drive, check combinational hazard, clock, compare registers
    task automatic step(input vec_t v);
        step_no++;
        v.rsd = $urandom(); v.rtd = $urandom(); v.imm = $urandom();
        v.ctrl = 8'($urandom());
        drive(v);
        #1;
        chk("hazard", {31'b0, o_load_use_hazard}, {31'b0, v.haz});
        model_next(v);
        @(posedge i_clk);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_valid"}, {31'b0, o_valid}, 32'h0);
        chk({nm, "_rw"},    {29'b0, o_reg_write, o_mem_read, o_mem_write}, 32'h0);
        chk({nm, "_rd"},    {27'b0, o_rd}, 32'h0);
        chk({nm, "_idx"},   {22'b0, o_rs, o_rt}, 32'h0);
        chk({nm, "_data"},  o_rs_data | o_rt_data | o_imm, 32'h0);
        chk({nm, "_ctrl"},  {24'b0, o_ctrl}, 32'h0);
        chk({nm, "_sels"},  {26'b0, o_fwd_a_sel, o_fwd_b_sel, o_fwd_st_sel}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t r;
        //            en fl vl rs  rt  rd  alu urt rw mr mw exrd exrw haz
        tbl[0]  = mkv(1, 0, 1, 1,  2,  3,  0,  1,  1, 0, 0, 0,  0,  0);
        tbl[1]  = mkv(1, 0, 1, 3,  4,  9,  0,  1,  1, 0, 0, 0,  0,  0); // near fwd on rs
        tbl[2]  = mkv(1, 0, 1, 1,  2,  7,  0,  1,  1, 0, 0, 0,  0,  0);
        tbl[3]  = mkv(1, 0, 1, 7,  7,  10, 1,  1,  0, 0, 0, 7,  1,  0); // near beats far
        tbl[4]  = mkv(1, 0, 1, 7,  7,  11, 0,  1,  0, 0, 0, 7,  1,  0); // far only
        tbl[5]  = mkv(1, 0, 1, 2,  3,  0,  0,  1,  1, 0, 0, 0,  0,  0);
        tbl[6]  = mkv(1, 0, 1, 0,  0,  8,  0,  1,  1, 1, 0, 0,  1,  0); // index 0
        tbl[7]  = mkv(1, 1, 1, 1,  8,  2,  0,  1,  1, 0, 0, 0,  0,  1); // load-use rt, flush
        tbl[8]  = mkv(1, 0, 1, 2,  8,  8,  0,  1,  1, 1, 0, 0,  0,  0);
        tbl[9]  = mkv(1, 0, 1, 8,  8,  12, 0,  0,  1, 1, 0, 0,  0,  1); // load-use rs
        tbl[10] = mkv(1, 0, 0, 1,  12, 4,  0,  1,  1, 1, 1, 0,  0,  0); // invalid ID
        tbl[11] = mkv(1, 0, 1, 3,  1,  6,  0,  0,  1, 1, 0, 0,  0,  0);
        tbl[12] = mkv(0, 0, 1, 6,  2,  14, 0,  0,  1, 0, 0, 6,  1,  1); // hold
        tbl[13] = mkv(0, 0, 1, 1,  6,  15, 1,  1,  0, 0, 1, 3,  1,  1); // hold
        tbl[14] = mkv(0, 1, 1, 6,  0,  16, 0,  0,  1, 0, 0, 0,  0,  1); // hold beats flush
        tbl[15] = mkv(1, 0, 1, 6,  6,  13, 0,  1,  1, 0, 0, 0,  0,  1);
        tbl[16] = mkv(1, 0, 1, 13, 5,  17, 1,  1,  0, 0, 1, 13, 1,  0);
        tbl[17] = mkv(1, 0, 1, 5,  13, 18, 0,  1,  1, 1, 0, 5,  1,  0);
        tbl[18] = mkv(1, 0, 1, 2,  18, 19, 1,  0,  1, 0, 0, 0,  0,  0); // rt not used

        // Power-on reset
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        m = '{default: '0};
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 19; i++) step(tbl[i]);

        // Asynchronous reset between edges while holding a valid rd=5
        step(mkv(1, 0, 1, 1, 2, 5, 0, 1, 1, 0, 0, 0, 0, 0));
        chk("pre_reset_valid", {31'b0, o_valid}, 32'h1);
        i_enable = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        m = '{default: '0};
        @(posedge i_clk);
        #1;

        // Random traffic over a small index range to provoke matches
        for (int k = 0; k < 40; k++) begin
            r = mkv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 5) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            r.haz = mhaz(r);
            step(r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the five-stage pipeline: captures decoded operands, immediate and control from ID and presents them to EX. It also precomputes, one cycle early, the 2-bit select codes that drive the three EX-stage 4:1 operand/forwarding multiplexers (ALU A, ALU B, store data). It reports load-use hazards against the instruction it holds, so the upstream hazard logic can stall IF/ID and request a bubble.

## Interface
- NB_DATA, 32, datapath width
- NB_REG, 5, register-index width
- NB_CTRL, 8, opaque control bits passed through unchanged (ALU op, branch, width, ...)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global step enable from the debug unit; low = hold all state
- i_flush  in  1  load a bubble instead of the ID instruction
- i_valid  in  1  ID holds a real instruction
- i_rs, i_rt, i_rd  in  NB_REG  source and destination indices
- i_rs_data, i_rt_data  in  NB_DATA  register-file read data
- i_imm  in  NB_DATA  extended immediate
- i_alu_src  in  1  ALU B takes the immediate
- i_uses_rt  in  1  instruction reads rt (R-type, store, branch)
- i_reg_write, i_mem_read, i_mem_write  in  1  control
- i_ctrl  in  NB_CTRL  passthrough control
- i_exmem_rd  in  NB_REG  destination currently in EX/MEM
- i_exmem_reg_write  in  1  EX/MEM writes a register
- o_valid, o_reg_write, o_mem_read, o_mem_write  out  1  registered control
- o_rs, o_rt, o_rd  out  NB_REG  registered indices
- o_rs_data, o_rt_data, o_imm  out  NB_DATA  registered data
- o_ctrl  out  NB_CTRL  registered passthrough
- o_fwd_a_sel, o_fwd_b_sel, o_fwd_st_sel  out  2  registered mux selects
- o_load_use_hazard  out  1  combinational hazard flag

## Operation
- Select encoding for all three muxes: 00 register-file data, 01 EX/MEM ALU result, 10 MEM/WB write-back value, 11 o_imm. Code 11 is used only on o_fwd_b_sel.
- Forward match for a source index s, evaluated in ID:
  - "near" = o_valid & o_reg_write & o_rd!=0 & o_rd==s. This instruction is in EX/MEM next cycle.
  - "far" = i_exmem_reg_write & i_exmem_rd!=0 & i_exmem_rd==s. This instruction is in MEM/WB next cycle.
  - Near has priority over far. Neither match gives 00.
- Select rules:
  - fwd_a = match(i_rs).
  - fwd_st = match(i_rt).
  - fwd_b = 11 if i_alu_src, else match(i_rt).
- o_load_use_hazard = o_valid & o_mem_read & o_rd!=0 & (o_rd==i_rs | (i_uses_rt & o_rd==i_rt)) & i_valid. It is not gated by i_enable.
- Register update priority, evaluated each rising edge:
  1. Reset: everything cleared.
  2. i_enable=0: hold every register, including the selects.
  3. i_flush=1: bubble. o_valid, o_reg_write, o_mem_read and o_mem_write go to 0; selects go to 00; data, index and ctrl registers may load or hold (don't care).
  4. Otherwise: load all inputs. o_reg_write, o_mem_read and o_mem_write are loaded ANDed with i_valid.
- i_flush and i_enable=0 together: hold wins.

## Timing
- Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
- Selects are valid in the same cycle as the data they steer; there is no combinational path from EX.
- Reset, asynchronous: all outputs 0 and all selects 00. Release is synchronous to i_clk. Reset mid-stream discards the held instruction.
- Index 0 never forwards, even with reg_write set.

## Configuration
- Macro: ID_EX_FWD_PRECOMPUTE_EN.
- Defined: forwarding selects are computed as above.
- Undefined:
  - o_fwd_a_sel and o_fwd_st_sel are constant 00.
  - o_fwd_b_sel is 11 when i_alu_src, else 00 (registered under the same priority rules).
  - Compare logic is removed. Software must insert NOPs.
  - o_load_use_hazard stays functional in both builds.

## Structure
- Shared package holds:
  - select constants FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_IMM=2'b11
  - default widths NB_DATA and NB_REG
- One sub-module, fwd_select, instantiated three times. It is combinational match logic (index, near/far candidates → 2-bit code); the registered selects live in id_ex_stage_reg.

## Test plan
- Reset asserted mid-operation with o_valid=1, o_rd=5 → all outputs 0 and selects 00 immediately, before the next edge.
- Near forward: held add with rd=3, reg_write=1; ID presents rs=3, i_alu_src=0, rt=4 → next cycle o_fwd_a_sel=01, o_fwd_b_sel=00.
- Priority: held rd=7 and i_exmem_rd=7, both writing; ID rs=7 → next cycle o_fwd_a_sel=01. Remove the held match → 10.
- Zero register: held rd=0, reg_write=1; ID rs=0 → next cycle o_fwd_a_sel=00.
- Load-use: held lw with rd=8; ID rt=8, i_uses_rt=1 → o_load_use_hazard=1 in the same cycle. Drive i_flush=1 → next cycle o_valid=0, o_mem_read=0, selects 00.
- Hold: i_enable=0 for 3 cycles with changing inputs → outputs unchanged. With i_flush=1 and i_enable=0 → no bubble inserted.
